// File: rtl/serial_pin_ctrl_pkg.sv
// Shared definitions for serial_pin_ctrl: state encoding and frame geometry.
// Frame length depends on the SERIAL_PIN_CTRL_FRAMING_EN macro (start/stop bits).
package serial_pin_ctrl_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   function automatic int frame_len(input int w);
`ifdef SERIAL_PIN_CTRL_FRAMING_EN
      return w + 2;
`else
      return w;
`endif
   endfunction

   // A one-bit frame still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_pin_ctrl_dffe.sv
// Clock-enabled IO output register. It has no reset: the controller forces
// e=1/d=IDLE during reset so the pin settles on the first clock edge.
module dffe_out (
   input  logic clk,
   input  logic d,
   input  logic e,
   output logic q
);

   // Pin register, loads only when enabled.
   always_ff @(posedge clk) begin
      if (e) begin
         q <= d;
      end
   end

endmodule

// File: rtl/serial_pin_ctrl.sv
// Bit-serial sequencer driving one registered pin, LSB-first, programmable bit period.
// Optional start/stop framing is enabled by defining SERIAL_PIN_CTRL_FRAMING_EN.
module serial_pin_ctrl
   import serial_pin_ctrl_pkg::*;
#(
   parameter int   W     = 8,
   parameter int   DIV_W = 16,
   parameter logic IDLE  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   input  logic [W-1:0]     tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             busy,
   output logic             pin
);

   localparam int N  = frame_len(W);
   localparam int BW = cnt_width(N);

   logic             state_r,   state_n;
   logic [N-1:0]     shift_r,   shift_n;
   logic [DIV_W-1:0] div_q_r,   div_q_n;
   logic [DIV_W-1:0] div_cnt_r, div_cnt_n;
   logic [BW-1:0]    bit_cnt_r, bit_cnt_n;
   logic             tx_ready_r, tx_ready_n;
   logic             busy_r,    busy_n;
   logic [N-1:0]     frame_s;
   logic             accept_s;
   logic             pin_d_s;
   logic             pin_e_s;

`ifdef SERIAL_PIN_CTRL_FRAMING_EN
   assign frame_s = {IDLE, tx_data, ~IDLE};
`else
   assign frame_s = tx_data;
`endif

   assign accept_s = tx_valid & tx_ready_r;
   assign tx_ready = tx_ready_r;
   assign busy     = busy_r;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         div_q_r    <= '0;
         div_cnt_r  <= '0;
         bit_cnt_r  <= '0;
         tx_ready_r <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         shift_r    <= shift_n;
         div_q_r    <= div_q_n;
         div_cnt_r  <= div_cnt_n;
         bit_cnt_r  <= bit_cnt_n;
         tx_ready_r <= tx_ready_n;
         busy_r     <= busy_n;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_n   = state_r;
      shift_n   = shift_r;
      div_q_n   = div_q_r;
      div_cnt_n = div_cnt_r;
      bit_cnt_n = bit_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_n   = ST_SHIFT;
               shift_n   = frame_s;
               div_q_n   = div;
               div_cnt_n = div;
               bit_cnt_n = BW'(N - 1);
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (div_cnt_r != '0) begin
               div_cnt_n = div_cnt_r - DIV_W'(1);
            end else if (bit_cnt_r != '0) begin
               shift_n   = shift_r >> 1;
               div_cnt_n = div_q_r;
               bit_cnt_n = bit_cnt_r - BW'(1);
            end else if (accept_s) begin
               // Back-to-back frame: reload with no idle gap.
               shift_n   = frame_s;
               div_q_n   = div;
               div_cnt_n = div;
               bit_cnt_n = BW'(N - 1);
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Handshake outputs are registered from the next-state view of the counters.
   always_comb begin
      tx_ready_n = (state_n == ST_IDLE) || ((bit_cnt_n == '0) && (div_cnt_n == '0));
      busy_n     = (state_n == ST_SHIFT);
   end

   // Pin register drive: enable only on the first cycle of each bit period.
   always_comb begin
      pin_d_s = IDLE;
      pin_e_s = 1'b1;
      case (state_r)
         ST_IDLE: begin
            pin_d_s = IDLE;
            pin_e_s = 1'b1;
         end
         ST_SHIFT: begin
            pin_d_s = shift_r[0];
            pin_e_s = (div_cnt_r == div_q_r);
         end
         default: begin
            pin_d_s = IDLE;
            pin_e_s = 1'b1;
         end
      endcase
   end

   dffe_out u_pin_reg (
      .clk (clk),
      .d   (pin_d_s),
      .e   (pin_e_s),
      .q   (pin)
   );

endmodule
